// File: rtl/div_if.sv
// Handshake bundle between the execute-stage issue logic and the divide unit.
// The master side issues operands and consumes results; the slave side is
// the divider itself.
interface div_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] result;
    logic                  busy;

    modport master (
        output flush,
        output in_valid,
        output op,
        output dividend,
        output divisor,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  busy
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  op,
        input  dividend,
        input  divisor,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output busy
    );
endinterface

// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit. One restoring-division step per
// cycle, with divide-by-zero and signed overflow resolved directly in the
// accept cycle. The result register drives the divide slot of the
// writeback-select mux and is held until the consumer takes it.
module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic clk,
    input  logic rst_n,
    div_if.slave dif
);
    localparam int                  CW        = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]       CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]       CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]       CNT_LAST  = CW'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] ZERO    = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's-complement negate when requested; also used for absolute value.
    function automatic logic [DATA_WIDTH-1:0] cond_neg(
        input logic [DATA_WIDTH-1:0] v,
        input logic                  neg
    );
        if (neg) begin
            cond_neg = ZERO - v;
        end else begin
            cond_neg = v;
        end
    endfunction

    state_t                state_r, state_n;
    logic [CW-1:0]         cnt_r, cnt_n;
    logic [DATA_WIDTH-1:0] rem_r, rem_n;
    logic [DATA_WIDTH-1:0] quo_r, quo_n;
    logic [DATA_WIDTH-1:0] dvs_r, dvs_n;
    logic                  is_rem_r, is_rem_n;
    logic                  neg_q_r, neg_q_n;
    logic                  neg_r_r, neg_r_n;
    logic [DATA_WIDTH-1:0] result_r, result_n;

    logic                  accept_s;
    logic                  signed_op_s;
    logic                  dd_neg_s;
    logic                  dv_neg_s;
    logic                  div_zero_s;
    logic                  ovf_s;
    logic                  special_s;
    logic                  last_step_s;
    logic [DATA_WIDTH-1:0] dd_mag_s;
    logic [DATA_WIDTH-1:0] dv_mag_s;
    logic [DATA_WIDTH-1:0] special_res_s;
    logic [DATA_WIDTH:0]   rem_sh_s;
    logic [DATA_WIDTH:0]   diff_s;
    logic [DATA_WIDTH-1:0] step_rem_s;
    logic [DATA_WIDTH-1:0] step_quo_s;
    logic [DATA_WIDTH-1:0] fin_q_s;
    logic [DATA_WIDTH-1:0] fin_r_s;

    // op[0] selects unsigned; op[1] selects remainder.
    assign accept_s    = dif.in_valid & (state_r == ST_IDLE);
    assign signed_op_s = ~dif.op[0];
    assign dd_neg_s    = signed_op_s & dif.dividend[DATA_WIDTH-1];
    assign dv_neg_s    = signed_op_s & dif.divisor[DATA_WIDTH-1];
    assign dd_mag_s    = cond_neg(dif.dividend, dd_neg_s);
    assign dv_mag_s    = cond_neg(dif.divisor, dv_neg_s);
    assign div_zero_s  = (dif.divisor == ZERO);
    assign ovf_s       = signed_op_s & (dif.dividend == MIN_NEG) & (dif.divisor == ALL_ONES);
    assign special_s   = div_zero_s | ovf_s;
    assign last_step_s = (cnt_r == CNT_LAST);

    // Directly computed result for divide-by-zero and signed overflow.
    always_comb begin
        special_res_s = ZERO;
        if (div_zero_s) begin
            special_res_s = dif.op[1] ? dif.dividend : ALL_ONES;
        end else begin
            special_res_s = dif.op[1] ? ZERO : MIN_NEG;
        end
    end

    // One restoring step: shift {rem,quo} left, trial-subtract with a
    // DATA_WIDTH+1-bit difference so the borrow is visible in the MSB.
    always_comb begin
        rem_sh_s   = {rem_r, quo_r[DATA_WIDTH-1]};
        diff_s     = rem_sh_s - {1'b0, dvs_r};
        step_rem_s = rem_r;
        step_quo_s = quo_r;
        if (diff_s[DATA_WIDTH] == 1'b0) begin
            step_rem_s = diff_s[DATA_WIDTH-1:0];
            step_quo_s = {quo_r[DATA_WIDTH-2:0], 1'b1};
        end else begin
            step_rem_s = rem_sh_s[DATA_WIDTH-1:0];
            step_quo_s = {quo_r[DATA_WIDTH-2:0], 1'b0};
        end
        fin_q_s = cond_neg(step_quo_s, neg_q_r);
        fin_r_s = cond_neg(step_rem_s, neg_r_r);
    end

    // Next-state decode; flush overrides everything except reset.
    always_comb begin
        state_n = state_r;
        if (dif.flush) begin
            state_n = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_n = special_s ? ST_DONE : ST_CALC;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (last_step_s) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_CALC;
                    end
                end
                ST_DONE: begin
                    if (dif.out_ready) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // Datapath next values: latch operands on accept, iterate in CALC,
    // and leave the result register untouched on flush.
    always_comb begin
        cnt_n    = cnt_r;
        rem_n    = rem_r;
        quo_n    = quo_r;
        dvs_n    = dvs_r;
        is_rem_n = is_rem_r;
        neg_q_n  = neg_q_r;
        neg_r_n  = neg_r_r;
        result_n = result_r;
        if (dif.flush) begin
            result_n = result_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cnt_n    = CNT_ZERO;
                        rem_n    = ZERO;
                        quo_n    = dd_mag_s;
                        dvs_n    = dv_mag_s;
                        is_rem_n = dif.op[1];
                        neg_q_n  = dd_neg_s ^ dv_neg_s;
                        neg_r_n  = dd_neg_s;
                        if (special_s) begin
                            result_n = special_res_s;
                        end else begin
                            result_n = result_r;
                        end
                    end else begin
                        result_n = result_r;
                    end
                end
                ST_CALC: begin
                    rem_n = step_rem_s;
                    quo_n = step_quo_s;
                    if (last_step_s) begin
                        cnt_n    = cnt_r;
                        result_n = is_rem_r ? fin_r_s : fin_q_s;
                    end else begin
                        cnt_n = cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    result_n = result_r;
                end
                default: begin
                    result_n = result_r;
                end
            endcase
        end
    end

    // FSM state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Datapath and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r    <= CNT_ZERO;
            rem_r    <= ZERO;
            quo_r    <= ZERO;
            dvs_r    <= ZERO;
            is_rem_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            result_r <= ZERO;
        end else begin
            cnt_r    <= cnt_n;
            rem_r    <= rem_n;
            quo_r    <= quo_n;
            dvs_r    <= dvs_n;
            is_rem_r <= is_rem_n;
            neg_q_r  <= neg_q_n;
            neg_r_r  <= neg_r_n;
            result_r <= result_n;
        end
    end

    // Outputs are pure state decode or register copies.
    assign dif.in_ready  = (state_r == ST_IDLE);
    assign dif.out_valid = (state_r == ST_DONE);
    assign dif.busy      = (state_r != ST_IDLE);
    assign dif.result    = result_r;
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative RV32M divide/remainder unit for the NPC execute stage.
- Sits directly upstream of the 8:1 writeback-select mux and drives one of its data inputs (the divide-result slot).
- Accepts operands through a valid/ready handshake and computes one quotient bit per cycle using restoring division.
- Presents a registered result, held stable until the consumer accepts it.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even and ≥4. Iteration count equals DATA_WIDTH.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous reset, active-low
- flush  input  1  abort any in-flight operation, return to IDLE
- in_valid  input  1  operands and op valid
- in_ready  output  1  unit can accept (high only in IDLE)
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  input  DATA_WIDTH  rs1 value
- divisor  input  DATA_WIDTH  rs2 value
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  DATA_WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU); feeds writeback mux input
- busy  output  1  high in CALC or DONE

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State returns to IDLE.
  - out_valid=0, result=0, busy=0, in_ready=1.
  - Iteration counter and internal registers are cleared.
  - Reset has priority over flush and over every handshake.
- State machine, IDLE/CALC/DONE:
  - IDLE: in_ready=1. Handshake fires on in_valid&in_ready; op, operands and their signs are latched.
  - Special cases, detected in the accept cycle, go IDLE→DONE in the next cycle with the result computed directly (no CALC):
    - divisor==0: quotient = all ones; remainder = dividend. Applies to both signed and unsigned ops.
    - Signed overflow (DIV/REM, dividend=0x80000000, divisor=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
  - Otherwise IDLE→CALC. Latch magnitudes: two's-complement absolute value for signed ops, raw values for unsigned ops.
  - CALC: one restoring step per cycle.
    - Shift the {rem, quo} pair left by 1.
    - Trial subtract: rem − |divisor|, using a DATA_WIDTH+1-bit difference.
    - If non-negative, keep the difference and set the quotient LSB to 1.
    - The counter runs 0..DATA_WIDTH−1. On the last step, go to DONE and register the sign-corrected result.
  - Sign correction (signed ops only):
    - Negate the quotient when the dividend and divisor signs differ.
    - The remainder takes the sign of the dividend.
  - DONE: out_valid=1, result stable. On out_ready, go to DONE→IDLE and drop out_valid in the next cycle. Holds indefinitely while out_ready=0.
- Latency, counted from the accept edge to the first cycle out_valid=1:
  - Normal case: DATA_WIDTH+1 cycles (33 at default).
  - Special cases: 1 cycle.
- Throughput: the earliest next accept is the cycle after the out_ready handshake; there is no accept in the same cycle as a DONE→IDLE transition.
- flush:
  - In any state, the next cycle is IDLE with out_valid=0; the result register keeps its last value.
  - A flush in the same cycle as an accept discards the new operation.
  - A flush in DONE in the same cycle as out_ready: both take effect; the state goes to IDLE and the consumer's handshake counts as completed.
- Operand inputs are ignored outside the accept cycle; changing them during CALC has no effect.
- All outputs come from registers or state decode only; there is no combinational path from inputs to out_valid or result.

Test Plan:
- Reset mid-CALC (rst_n low 1 cycle at iteration 10) → next cycle: IDLE, in_ready=1, out_valid=0, result=0.
- DIVU 100/7 → out_valid exactly 33 cycles after accept, result=14; REMU 100/7 → 2.
- DIV −7 (0xFFFFFFF9) / 2 → 0xFFFFFFFD (−3); REM −7/2 → 0xFFFFFFFF (−1); DIV 7/−2 → 0xFFFFFFFD.
- Divide by zero, DIV 5/0 → result=0xFFFFFFFF, latency 1. REMU 5/0 → 5. Overflow DIV 0x80000000/−1 → 0x80000000; REM → 0, latency 1.
- Backpressure: hold out_ready=0 for 20 cycles in DONE → result and out_valid stay stable, in_ready=0. Pulse out_ready → out_valid falls next cycle; a back-to-back new op is accepted the following cycle.
- flush at iteration 5 → IDLE next cycle, no out_valid pulse. A subsequent DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF.
